mem_slave: RTL and testbench
============================

MEM_SLAVE -- requirements
Module: mem_slave

Interface
REQ-001 The block SHALL have one parameter: DEPTH_LOG2, default 10, giving log2 of the number of 16-bit words of storage.
REQ-002 The block SHALL have one parameter: BASE, default 0, giving the value that addr[19:DEPTH_LOG2+1] must match for a request to be inside the window.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 boot  input  1  reset, asynchronous and active-low.
REQ-005 req  input  1  one-cycle request strobe from the CPU memory port.
REQ-006 addr  input  20  byte address.
REQ-007 we  input  1  write enable, active-low (0 = write, 1 = read).
REQ-008 byte_m  input  1  1 = byte access, 0 = word access.
REQ-009 wr_data  input  16  write data; byte writes use wr_data[7:0].
REQ-010 rd_data  output  16  registered read data.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high while a request is in progress and a new req is ignored.

Function
REQ-013 Storage SHALL be one single-port array of 2^DEPTH_LOG2 words, 16 bits each, with per-byte write enables. Word index w = addr[DEPTH_LOG2:1]. The low byte holds the even address and the high byte holds the odd address.
REQ-014 The FSM SHALL have three states: IDLE, SECOND and DONE. busy = (state != IDLE). ack = (state == DONE).
REQ-015 req SHALL be accepted only in IDLE. A req in SECOND or DONE SHALL be ignored, with no side effects.
REQ-016 An accepted request is aligned if byte_m=1 or addr[0]=0.
REQ-017 Aligned request: the single access SHALL occur at the accepting edge T, and the state SHALL go IDLE->DONE. ack=1 during cycle T+1; the state returns to IDLE at T+1's edge.
REQ-018 Unaligned word request (byte_m=0, addr[0]=1) has two accesses.
- First access at edge T touches word w, high byte only.
- Second access at edge T+1 touches word (w+1) mod 2^DEPTH_LOG2, low byte only.
- State path IDLE->SECOND->DONE; ack=1 during cycle T+2.
REQ-019 addr, we, byte_m and wr_data SHALL be captured at acceptance. Inputs SHALL be ignored until the state returns to IDLE.
REQ-020 Word read: rd_data = {mem[a+1], mem[a]} in byte-address terms, and SHALL be valid while ack=1.
REQ-021 Byte read: rd_data = {8'h00, mem[a]}.
REQ-022 Write: bytes SHALL be written low-byte-first from wr_data. rd_data SHALL hold its previous value.
REQ-023 Word-index wrap-around (REQ-018) SHALL occur silently, with no error indication.
REQ-024 Request outside the window (addr[19:DEPTH_LOG2+1] != BASE):
- SHALL follow the same timing as an aligned/unaligned request of the same shape, including ack.
- SHALL perform no write.
- SHALL return rd_data=16'hFFFF on reads.
REQ-025 An unaligned word whose second byte leaves the window SHALL wrap inside the window per REQ-023; window membership is decided from the first address only.
REQ-026 rd_data SHALL change only on the edge that enters DONE for a read.

Reset
REQ-027 When boot=0, the following SHALL hold asynchronously: state=IDLE, ack=0, busy=0, rd_data=16'h0000, captured request registers cleared.
REQ-028 Reset mid-operation (in SECOND) SHALL abort the request. No second-byte write SHALL occur and no ack SHALL be issued. The first-byte write already done SHALL remain.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 The first req SHALL be accepted on the first rising edge with boot=1.

Verification
REQ-031 Aligned word write, then read.
- Stimulus: write addr=0x00010, wr_data=0xBEEF; then read addr=0x00010.
- Response: ack 1 cycle after each req; read returns rd_data=0xBEEF with busy high exactly 1 cycle.
REQ-032 Byte reads of a stored word.
- Stimulus: after REQ-031, byte read 0x00011, then byte read 0x00010.
- Response: rd_data=0x00BE, then 0x00EF.
REQ-033 Unaligned word write.
- Stimulus: write 0x00021=0x1234, then word read 0x00020 and word read 0x00022.
- Response: ack at T+2 for the write; the reads return 0x34xx and 0xxx12, with the untouched bytes preserved.
REQ-034 Unaligned access at the top word (DEPTH_LOG2=10).
- Stimulus: word write to addr=0x007FF with 0xA55A.
- Response: byte 0x007FF=0x5A and byte 0x00000=0xA5; the second access wraps to word 0.
REQ-035 Out-of-window access and ignored req.
- Stimulus: read 0x80000 with BASE=0; also a req asserted while busy=1.
- Response: rd_data=0xFFFF with ack at T+1, memory unchanged; the req while busy produces no ack and no write.
REQ-036 Reset mid-operation.
- Stimulus: boot=0 during SECOND of an unaligned write 0x00031=0xCAFE.
- Response: ack never pulses; byte 0x00031=0xFE; byte 0x00032 unchanged; busy=0 immediately.

Source files
------------

// File: rtl/mem_slave.sv
// mem_slave: single-port 16-bit word memory behind a byte-addressed CPU port.
// Accepts one request at a time. Aligned accesses finish in one access cycle.
// Unaligned word accesses take two: the high byte of word w, then the low
// byte of word w+1, which wraps inside the array. Requests outside the
// address window are timed normally but never write and read back 16'hFFFF.
//
// Ports:
//   clk      in   clock, rising edge
//   boot     in   asynchronous active-low reset
//   req      in   one-cycle request strobe (honoured only when idle)
//   addr     in   [19:0] byte address
//   we       in   write enable, active-low (0 = write, 1 = read)
//   byte_m   in   1 = byte access, 0 = word access
//   wr_data  in   [15:0] write data (byte writes use [7:0])
//   rd_data  out  [15:0] registered read data, valid while ack is high
//   ack      out  one-cycle completion pulse
//   busy     out  high while a request is in progress
module mem_slave #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int unsigned BASE       = 0
) (
    input  logic        clk,
    input  logic        boot,
    input  logic        req,
    input  logic [19:0] addr,
    input  logic        we,
    input  logic        byte_m,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        ack,
    output logic        busy
);

    localparam int                    TAGW     = 19 - DEPTH_LOG2;
    localparam int                    WORDS    = 1 << DEPTH_LOG2;
    localparam logic [TAGW-1:0]       BASE_TAG = TAGW'(BASE);
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        DONE
    } state_t;

    state_t                  state_q;
    logic [DEPTH_LOG2-1:0]   widx_q;
    logic                    we_q;
    logic                    win_q;
    logic [7:0]              wdata_hi_q;
    logic [7:0]              rd_lo_q;
    logic [15:0]             rd_data_q;
    logic                    ack_q;
    logic                    busy_q;

    logic [15:0]             mem [WORDS];

    logic                    idle;
    logic                    in_win;
    logic                    aligned;
    logic [DEPTH_LOG2-1:0]   idx_d;
    logic [15:0]             rd_word;
    logic [15:0]             rd_first_d;
    logic                    wen_lo;
    logic                    wen_hi;
    logic [7:0]              wd_lo;
    logic [7:0]              wd_hi;

    always_comb begin
        idle    = (state_q == IDLE);
        in_win  = (addr[19:DEPTH_LOG2+1] == BASE_TAG);
        aligned = byte_m | ~addr[0];
        // The single port is shared: live address when idle, otherwise the
        // following word (with natural wrap) for the second half of an
        // unaligned access.
        idx_d   = idle ? addr[DEPTH_LOG2:1] : widx_q + IDX_ONE;
        rd_word = mem[idx_d];

        wen_lo  = 1'b0;
        wen_hi  = 1'b0;
        wd_lo   = wr_data[7:0];
        wd_hi   = wr_data[7:0];
        if (idle && req && !we && in_win) begin
            if (byte_m) begin
                if (addr[0]) wen_hi = 1'b1;
                else         wen_lo = 1'b1;
            end else if (addr[0]) begin
                // Unaligned word: first byte goes into the odd (high) half.
                wen_hi = 1'b1;
            end else begin
                wen_lo = 1'b1;
                wen_hi = 1'b1;
                wd_hi  = wr_data[15:8];
            end
        end else if ((state_q == SECOND) && !we_q && win_q) begin
            wen_lo = 1'b1;
            wd_lo  = wdata_hi_q;
        end

        if (!in_win)     rd_first_d = 16'hFFFF;
        else if (byte_m) rd_first_d = {8'h00, (addr[0] ? rd_word[15:8] : rd_word[7:0])};
        else             rd_first_d = rd_word;
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wen_lo) mem[idx_d][7:0]  <= wd_lo;
        if (wen_hi) mem[idx_d][15:8] <= wd_hi;
    end

    always_ff @(posedge clk or negedge boot) begin
        if (!boot) begin
            state_q    <= IDLE;
            widx_q     <= '0;
            we_q       <= 1'b1;
            win_q      <= 1'b0;
            wdata_hi_q <= 8'h00;
            rd_lo_q    <= 8'h00;
            rd_data_q  <= 16'h0000;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        widx_q     <= addr[DEPTH_LOG2:1];
                        we_q       <= we;
                        win_q      <= in_win;
                        wdata_hi_q <= wr_data[15:8];
                        busy_q     <= 1'b1;
                        if (aligned) begin
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                            if (we) rd_data_q <= rd_first_d;
                        end else begin
                            state_q <= SECOND;
                            // Hold the odd byte until the second access completes the word.
                            rd_lo_q <= rd_word[15:8];
                        end
                    end
                end
                SECOND: begin
                    state_q <= DONE;
                    ack_q   <= 1'b1;
                    if (we_q) rd_data_q <= win_q ? {rd_word[7:0], rd_lo_q} : 16'hFFFF;
                end
                DONE: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data = rd_data_q;
    assign ack     = ack_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_slave.sv
// Directed bench for mem_slave (DEPTH_LOG2=10, BASE=0).
module tb_mem_slave;

    logic        clk = 1'b0;
    logic        boot;
    logic        req;
    logic [19:0] addr;
    logic        we;
    logic        byte_m;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        ack;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    int          lat;
    int          bcnt;
    int          acks;
    logic [15:0] rd;

    mem_slave #(.DEPTH_LOG2(10), .BASE(0)) dut (
        .clk     (clk),
        .boot    (boot),
        .req     (req),
        .addr    (addr),
        .we      (we),
        .byte_m  (byte_m),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .ack     (ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: returns ack latency (cycles after the accepting edge),
    // number of busy cycles observed, and rd_data sampled while ack is high.
    task automatic xfer(input logic [19:0] a, input logic w, input logic b,
                        input logic [15:0] d, output int l, output int bc,
                        output logic [15:0] r);
        @(negedge clk);
        req = 1'b1; addr = a; we = w; byte_m = b; wr_data = d;
        @(negedge clk);
        req = 1'b0;
        l  = 1;
        bc = busy ? 1 : 0;
        while (!ack && l < 10) begin
            @(negedge clk);
            l++;
            if (busy) bc++;
        end
        r = rd_data;
        @(negedge clk);
    endtask

    initial begin
        boot = 1'b0; req = 1'b0; addr = '0; we = 1'b1; byte_m = 1'b0; wr_data = '0;
        @(negedge clk); @(negedge clk);
        check("rst_rd",   rd_data, 16'h0000);
        check("rst_ack",  {15'd0, ack},  16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        boot = 1'b1;

        // Aligned word write then read.
        xfer(20'h00010, 1'b0, 1'b0, 16'hBEEF, lat, bcnt, rd);
        check("w10_lat", 16'(lat), 16'd1);
        check("w10_rd_hold", rd, 16'h0000);
        xfer(20'h00010, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("r10_lat",  16'(lat),  16'd1);
        check("r10_busy", 16'(bcnt), 16'd1);
        check("r10_data", rd, 16'hBEEF);
        check("r10_idle", {15'd0, busy}, 16'd0);

        // Byte reads.
        xfer(20'h00011, 1'b1, 1'b1, 16'h0000, lat, bcnt, rd);
        check("rb11", rd, 16'h00BE);
        xfer(20'h00010, 1'b1, 1'b1, 16'h0000, lat, bcnt, rd);
        check("rb10", rd, 16'h00EF);

        // Unaligned word write over known neighbours.
        xfer(20'h00020, 1'b0, 1'b0, 16'h5566, lat, bcnt, rd);
        check("w20_rd_hold", rd, 16'h00EF);
        xfer(20'h00022, 1'b0, 1'b0, 16'h7788, lat, bcnt, rd);
        xfer(20'h00021, 1'b0, 1'b0, 16'h1234, lat, bcnt, rd);
        check("w21_lat",  16'(lat),  16'd2);
        check("w21_busy", 16'(bcnt), 16'd2);
        xfer(20'h00020, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("r20", rd, 16'h3466);
        xfer(20'h00022, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("r22", rd, 16'h7712);

        // Byte writes into an existing word.
        xfer(20'h00023, 1'b0, 1'b1, 16'hFF99, lat, bcnt, rd);
        check("wb23_lat", 16'(lat), 16'd1);
        xfer(20'h00022, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("r22_b", rd, 16'h9912);

        // Unaligned write at the top word wraps to word 0.
        xfer(20'h007FF, 1'b0, 1'b0, 16'hA55A, lat, bcnt, rd);
        check("w7ff_lat", 16'(lat), 16'd2);
        xfer(20'h007FF, 1'b1, 1'b1, 16'h0000, lat, bcnt, rd);
        check("rb7ff", rd, 16'h005A);
        xfer(20'h00000, 1'b1, 1'b1, 16'h0000, lat, bcnt, rd);
        check("rb000", rd, 16'h00A5);
        xfer(20'h007FF, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("r7ff_lat", 16'(lat), 16'd2);
        check("r7ff", rd, 16'hA55A);

        // Out of window: read returns FFFF, write aliasing word 8 does nothing.
        xfer(20'h80000, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("oow_lat", 16'(lat), 16'd1);
        check("oow_rd",  rd, 16'hFFFF);
        xfer(20'h80010, 1'b0, 1'b0, 16'h1111, lat, bcnt, rd);
        check("oow_w_lat", 16'(lat), 16'd1);
        xfer(20'h00010, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("oow_nowr", rd, 16'hBEEF);
        xfer(20'h80021, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("oow_un_lat", 16'(lat), 16'd2);
        check("oow_un_rd",  rd, 16'hFFFF);

        // req held high while busy must be ignored.
        xfer(20'h00040, 1'b0, 1'b0, 16'h0102, lat, bcnt, rd);
        xfer(20'h00042, 1'b0, 1'b0, 16'h0304, lat, bcnt, rd);
        xfer(20'h00050, 1'b0, 1'b0, 16'h0A0B, lat, bcnt, rd);
        @(negedge clk);
        req = 1'b1; addr = 20'h00041; we = 1'b0; byte_m = 1'b0; wr_data = 16'hBBCC;
        @(negedge clk);
        check("ign_busy", {15'd0, busy}, 16'd1);
        check("ign_ack0", {15'd0, ack},  16'd0);
        addr = 20'h00050; wr_data = 16'h9999;
        @(negedge clk);
        check("ign_ack1", {15'd0, ack}, 16'd1);
        addr = 20'h00052;
        @(negedge clk);
        req = 1'b0;
        check("ign_ack2", {15'd0, ack},  16'd0);
        check("ign_idle", {15'd0, busy}, 16'd0);
        @(negedge clk);
        check("ign_noacc", {15'd0, busy}, 16'd0);
        xfer(20'h00050, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("ign_r50", rd, 16'h0A0B);
        xfer(20'h00040, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("ign_r40", rd, 16'hCC02);
        xfer(20'h00042, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("ign_r42", rd, 16'h03BB);

        // Reset during SECOND of an unaligned write.
        xfer(20'h00030, 1'b0, 1'b0, 16'h1122, lat, bcnt, rd);
        xfer(20'h00032, 1'b0, 1'b0, 16'h3344, lat, bcnt, rd);
        @(negedge clk);
        req = 1'b1; addr = 20'h00031; we = 1'b0; byte_m = 1'b0; wr_data = 16'hCAFE;
        @(negedge clk);
        req = 1'b0;
        check("mid_busy", {15'd0, busy}, 16'd1);
        #1 boot = 1'b0;
        #1;
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        check("mid_rst_ack",  {15'd0, ack},  16'd0);
        check("mid_rst_rd",   rd_data, 16'h0000);
        @(negedge clk);
        boot = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("mid_noack", 16'(acks), 16'd0);
        xfer(20'h00031, 1'b1, 1'b1, 16'h0000, lat, bcnt, rd);
        check("mid_b31", rd, 16'h00FE);
        xfer(20'h00032, 1'b1, 1'b1, 16'h0000, lat, bcnt, rd);
        check("mid_b32", rd, 16'h0044);
        xfer(20'h00030, 1'b1, 1'b0, 16'h0000, lat, bcnt, rd);
        check("mid_r30", rd, 16'hFE22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
